// File: rtl/sobel_stream_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_stream_engine_pkg
//  Description : Shared types and constants for the streaming Sobel engine.
//                MAX_PIXEL_BITS is the widest pixel the datapath carries.
//                Narrower pixels are zero-extended into it. IMG_WIDTH and
//                IMG_HEIGHT take their defaults from here.
//  Revision    : 1.0  initial release
// ============================================================================
package sobel_stream_engine_pkg;

  localparam int MAX_PIXEL_BITS     = 8;
  localparam int DEFAULT_IMG_WIDTH  = 8;
  localparam int DEFAULT_IMG_HEIGHT = 8;

  // Signed gradient width. The largest |Gx| or |Gy| is 4*(2^P-1), and the
  // sum of both magnitudes stays below 2^(P+3).
  localparam int GRAD_BITS = MAX_PIXEL_BITS + 3;

  localparam logic [GRAD_BITS-1:0] SAT_MAX = GRAD_BITS'((1 << MAX_PIXEL_BITS) - 1);

  typedef logic [MAX_PIXEL_BITS-1:0] pixel_t;

  // 3x3 window indexed [row][col]. Row 0 is the top row and col 0 is the
  // left (oldest) column.
  typedef pixel_t [2:0][2:0] window_t;

  typedef logic signed [GRAD_BITS-1:0] grad_t;

  // Zero-extend a pixel into the signed gradient domain.
  function automatic grad_t to_grad(input pixel_t p);
    return grad_t'(p);
  endfunction

endpackage : sobel_stream_engine_pkg
`default_nettype wire

// File: rtl/sobel_kernel.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_kernel
//  Description : Two-stage Sobel datapath.
//                Stage 1 registers Gx, Gy and the border/last tags.
//                Stage 2 registers the saturated |Gx|+|Gy| and masks border
//                results to zero. mag_o holds its value between updates.
//  Ports       : clk_i, nreset_i      clock, async active-low reset
//                valid_i              window_i holds a newly shifted window
//                border_i             result must be forced to zero
//                last_i               window belongs to the last pixel of a frame
//                window_i             3x3 window [row][col]
//                mag_o                saturated magnitude (held)
//                valid_o              one-cycle pulse when mag_o updates
//                last_o               one-cycle pulse with the last result
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_kernel
  import sobel_stream_engine_pkg::*;
#(
  parameter int PX_BITS = MAX_PIXEL_BITS
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               valid_i,
  input  logic               border_i,
  input  logic               last_i,
  input  window_t            window_i,
  output logic [PX_BITS-1:0] mag_o,
  output logic               valid_o,
  output logic               last_o
);

  // Saturation limit for the configured pixel width (2^PX_BITS - 1).
  localparam logic [GRAD_BITS-1:0] c_sat_max = SAT_MAX >> (MAX_PIXEL_BITS - PX_BITS);

  grad_t                 w_gx;
  grad_t                 w_gy;
  logic [GRAD_BITS-1:0]  w_abs_gx;
  logic [GRAD_BITS-1:0]  w_abs_gy;
  logic [GRAD_BITS-1:0]  w_sum;
  logic [PX_BITS-1:0]    w_mag;
  logic                  w_unused_centre;

  grad_t                 r_gx;
  grad_t                 r_gy;
  logic                  r_valid1;
  logic                  r_border1;
  logic                  r_last1;
  logic [PX_BITS-1:0]    r_mag;
  logic                  r_valid2;
  logic                  r_last2;

  // The centre tap has zero weight in both Sobel kernels.
  assign w_unused_centre = ^window_i[1][1];

  always_comb begin
    w_gx = (to_grad(window_i[0][2]) + (to_grad(window_i[1][2]) <<< 1) + to_grad(window_i[2][2]))
         - (to_grad(window_i[0][0]) + (to_grad(window_i[1][0]) <<< 1) + to_grad(window_i[2][0]));
    w_gy = (to_grad(window_i[2][0]) + (to_grad(window_i[2][1]) <<< 1) + to_grad(window_i[2][2]))
         - (to_grad(window_i[0][0]) + (to_grad(window_i[0][1]) <<< 1) + to_grad(window_i[0][2]));
  end

  // Stage 1: gradients
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_gx      <= '0;
      r_gy      <= '0;
      r_valid1  <= 1'b0;
      r_border1 <= 1'b0;
      r_last1   <= 1'b0;
    end else begin
      r_valid1 <= valid_i;
      if (valid_i) begin
        r_gx      <= w_gx;
        r_gy      <= w_gy;
        r_border1 <= border_i;
        r_last1   <= last_i;
      end
    end
  end

  always_comb begin
    w_abs_gx = r_gx[GRAD_BITS-1] ? GRAD_BITS'(-r_gx) : GRAD_BITS'(r_gx);
    w_abs_gy = r_gy[GRAD_BITS-1] ? GRAD_BITS'(-r_gy) : GRAD_BITS'(r_gy);
    w_sum    = w_abs_gx + w_abs_gy;
    w_mag    = (w_sum > c_sat_max) ? c_sat_max[PX_BITS-1:0] : w_sum[PX_BITS-1:0];
  end

  // Stage 2: saturated magnitude. The value is held while idle because the
  // consumer samples it asynchronously to the valid pulse.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_mag    <= '0;
      r_valid2 <= 1'b0;
      r_last2  <= 1'b0;
    end else begin
      r_valid2 <= r_valid1;
      r_last2  <= r_valid1 & r_last1;
      if (r_valid1) begin
        r_mag <= r_border1 ? '0 : w_mag;
      end
    end
  end

  assign mag_o   = r_mag;
  assign valid_o = r_valid2;
  assign last_o  = r_last2;

endmodule : sobel_kernel
`default_nettype wire

// File: rtl/sobel_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_stream_engine
//  Description : Streaming 3x3 Sobel stage. It takes one raster-order pixel
//                per strobe and keeps two line buffers and a 3x3 shift
//                window. It emits one saturated |Gx|+|Gy| per input pixel,
//                two cycles after the accepting edge. The result for pixel
//                (r,c) is centred on (r-1,c-1) and is zero on the two
//                leading rows and columns.
//  Ports       : clk_i, nreset_i    clock, async active-low reset
//                px_valid_i         one-cycle pixel strobe
//                px_gray_i          grayscale pixel
//                frame_start_i      restart: the next accepted pixel is (0,0)
//                px_sobel_o         last result, held between updates
//                px_sobel_valid_o   one-cycle pulse when px_sobel_o updates
//                frame_done_o       pulse with the result of pixel (H-1,W-1)
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_stream_engine
  import sobel_stream_engine_pkg::*;
#(
  parameter int PX_BITS    = MAX_PIXEL_BITS,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               px_valid_i,
  input  logic [PX_BITS-1:0] px_gray_i,
  input  logic               frame_start_i,
  output logic [PX_BITS-1:0] px_sobel_o,
  output logic               px_sobel_valid_o,
  output logic               frame_done_o
);

  localparam int c_col_w = $clog2(IMG_WIDTH);
  localparam int c_row_w = $clog2(IMG_HEIGHT);

  logic [c_col_w-1:0] r_col;
  logic [c_row_w-1:0] r_row;
  logic [c_col_w-1:0] w_col;
  logic [c_row_w-1:0] w_row;
  logic [c_col_w-1:0] w_col_nxt;
  logic [c_row_w-1:0] w_row_nxt;
  logic               w_col_last;
  logic               w_row_last;
  logic               w_border;
  pixel_t             w_px;

  pixel_t             r_lb0 [IMG_WIDTH];  // previous row
  pixel_t             r_lb1 [IMG_WIDTH];  // row before that
  window_t            r_window;
  logic               r_win_valid;
  logic               r_win_border;
  logic               r_win_last;

  assign w_px = pixel_t'(px_gray_i);

  // A frame restart takes effect in the same cycle. A coincident pixel
  // therefore sees position (0,0).
  always_comb begin
    w_col      = frame_start_i ? '0 : r_col;
    w_row      = frame_start_i ? '0 : r_row;
    w_col_last = (w_col == c_col_w'(IMG_WIDTH - 1));
    w_row_last = (w_row == c_row_w'(IMG_HEIGHT - 1));
    w_border   = (w_row < c_row_w'(2)) || (w_col < c_col_w'(2));
    w_col_nxt  = w_col;
    w_row_nxt  = w_row;
    if (px_valid_i) begin
      if (w_col_last) begin
        w_col_nxt = '0;
        w_row_nxt = w_row_last ? '0 : w_row + 1'b1;
      end else begin
        w_col_nxt = w_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_win_border <= 1'b0;
      r_win_last   <= 1'b0;
    end else begin
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_win_valid <= px_valid_i;
      if (px_valid_i) begin
        r_win_border <= w_border;
        r_win_last   <= w_row_last && w_col_last;
      end
    end
  end

  // Line buffers and window data need no reset. Any stale content only
  // reaches border positions, and those results are masked to zero.
  always_ff @(posedge clk_i) begin
    if (px_valid_i) begin
      for (int r = 0; r < 3; r++) begin
        r_window[r][0] <= r_window[r][1];
        r_window[r][1] <= r_window[r][2];
      end
      r_window[0][2] <= r_lb1[w_col];
      r_window[1][2] <= r_lb0[w_col];
      r_window[2][2] <= w_px;
      r_lb1[w_col]   <= r_lb0[w_col];
      r_lb0[w_col]   <= w_px;
    end
  end

  sobel_kernel #(
    .PX_BITS (PX_BITS)
  ) u_kernel (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .valid_i  (r_win_valid),
    .border_i (r_win_border),
    .last_i   (r_win_last),
    .window_i (r_window),
    .mag_o    (px_sobel_o),
    .valid_o  (px_sobel_valid_o),
    .last_o   (frame_done_o)
  );

endmodule : sobel_stream_engine
`default_nettype wire
